usb_tx: RTL and testbench

USB full-speed packet transmitter that sits between the protocol controller / TX data buffer and the D+/D− line drivers. On command it serialises a handshake packet (ACK or NAK) or a data packet: SYNC, PID, up to 64 payload bytes pulled from the data buffer, and CRC16. The serial stream is NRZI-encoded with bit stuffing, ends with an EOP, and the block reports completion to the protocol controller.

---
 rtl/usb_tx.sv | 206 ++++++++++++++++++++
 tb/tb_usb_tx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/usb_tx.sv
// usb_tx: USB full-speed packet transmitter (SYNC, PID, payload, CRC16)
// with NRZI line coding, bit stuffing and EOP generation.
module usb_tx (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [1:0] tx_packet,
   input  logic [7:0] tx_packet_data,
   input  logic [6:0] tx_packet_data_size,
   output logic       dPlus_out,
   output logic       dMinus_out,
   output logic       tx_done,
   output logic       get_tx_packet
);

   typedef enum logic [3:0] {
      IDLE, SYNC, PID, LOAD, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J
   } state_t;

   localparam logic [1:0] PKT_DATA = 2'b01;
   localparam logic [1:0] PKT_ACK  = 2'b10;

   state_t      r_state, w_state;
   logic [3:0]  r_tick, w_tick;
   logic [1:0]  r_phase, w_phase;
   logic [6:0]  r_shift, w_shift;
   logic [2:0]  r_bitcnt, w_bitcnt;
   logic [2:0]  r_ones, w_ones;
   logic [15:0] r_crc, w_crc;
   logic        r_level, w_level;
   logic [1:0]  r_type, w_type;
   logic [6:0]  r_left, w_left;
   logic        w_done, w_get, w_dp, w_dm;
   logic        w_bit_end, w_stuff_due;
   logic        w_emit, w_bit, w_count, w_crc_en, w_load;
   logic [7:0]  w_byte, w_pid;

   function automatic logic [15:0] f_crc(input logic [15:0] c,
                                         input logic b);
      logic [15:0] n;
      n = {1'b0, c[15:1]};
      if (c[0] ^ b) n = n ^ 16'hA001;
      return n;
   endfunction

   always_comb begin
      w_state  = r_state;
      w_tick   = r_tick;
      w_phase  = r_phase;
      w_shift  = r_shift;
      w_bitcnt = r_bitcnt;
      w_ones   = r_ones;
      w_crc    = r_crc;
      w_level  = r_level;
      w_type   = r_type;
      w_left   = r_left;
      w_done   = 1'b0;
      w_get    = 1'b0;
      w_emit   = 1'b0;
      w_bit    = 1'b0;
      w_count  = 1'b0;
      w_crc_en = 1'b0;
      w_load   = 1'b0;
      w_byte   = 8'h00;
      w_pid    = (r_type == PKT_DATA) ? 8'hC3 :
                 (r_type == PKT_ACK)  ? 8'hD2 : 8'h5A;
      // bit periods cycle through 8, 8, 9 clocks
      w_bit_end   = (r_tick == ((r_phase == 2'd2) ? 4'd8 : 4'd7));
      w_stuff_due = (r_ones == 3'd6) &&
                    (r_state inside {PID, DATA, CRC_LO, CRC_HI});

      if (r_state == IDLE) begin
         if (tx_packet != 2'b00) begin
            w_state = SYNC;
            w_tick  = 4'd0;
            w_phase = 2'd0;
            w_ones  = 3'd0;
            w_crc   = 16'hFFFF;
            w_type  = tx_packet;
            w_left  = (tx_packet_data_size > 7'd64) ? 7'd64
                                                    : tx_packet_data_size;
            w_load  = 1'b1;
            w_byte  = 8'h80;
         end
      end else if (!w_bit_end) begin
         w_tick = r_tick + 4'd1;
         if (r_state == LOAD) w_state = DATA;
      end else begin
         w_tick  = 4'd0;
         w_phase = (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
         if (w_stuff_due) begin
            w_emit  = 1'b1;
            w_bit   = 1'b0;
            w_count = 1'b1;
         end else if ((r_state inside {SYNC, PID, DATA, CRC_LO, CRC_HI})
                      && (r_bitcnt != 3'd7)) begin
            w_emit   = 1'b1;
            w_bit    = r_shift[0];
            w_shift  = {1'b0, r_shift[6:1]};
            w_bitcnt = r_bitcnt + 3'd1;
            w_count  = (r_state != SYNC);
            w_crc_en = (r_state == DATA);
         end else begin
            unique case (r_state)
               SYNC: begin
                  w_state = PID;
                  w_load  = 1'b1;
                  w_byte  = w_pid;
               end
               PID, DATA: begin
                  if (r_type != PKT_DATA) begin
                     w_state  = EOP_SE0;
                     w_bitcnt = 3'd0;
                  end else if (r_left != 7'd0) begin
                     w_state = LOAD;
                     w_get   = 1'b1;
                     w_load  = 1'b1;
                     w_byte  = tx_packet_data;
                     w_left  = r_left - 7'd1;
                  end else begin
                     w_state = CRC_LO;
                     w_load  = 1'b1;
                     w_byte  = ~r_crc[7:0];
                  end
               end
               CRC_LO: begin
                  w_state = CRC_HI;
                  w_load  = 1'b1;
                  w_byte  = ~r_crc[15:8];
               end
               CRC_HI: begin
                  w_state  = EOP_SE0;
                  w_bitcnt = 3'd0;
               end
               EOP_SE0: begin
                  if (r_bitcnt == 3'd0) begin
                     w_bitcnt = 3'd1;
                  end else begin
                     w_state = EOP_J;
                     w_level = 1'b1;
                     w_done  = 1'b1;
                  end
               end
               EOP_J:   w_state = IDLE;
               default: w_state = IDLE;
            endcase
         end
      end

      if (w_load) begin
         w_emit   = 1'b1;
         w_bit    = w_byte[0];
         w_shift  = w_byte[7:1];
         w_bitcnt = 3'd0;
         w_count  = (w_state != SYNC);
         w_crc_en = (w_state == LOAD);
      end

      if (w_emit) begin
         if (!w_bit) w_level = ~r_level;
         if (w_count) w_ones = w_bit ? r_ones + 3'd1 : 3'd0;
         if (w_crc_en) w_crc = f_crc(r_crc, w_bit);
      end

      w_dp = w_level;
      w_dm = ~w_level;
      if (w_state == EOP_SE0) begin
         w_dp = 1'b0;
         w_dm = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         r_state       <= IDLE;
         r_tick        <= 4'd0;
         r_phase       <= 2'd0;
         r_shift       <= 7'd0;
         r_bitcnt      <= 3'd0;
         r_ones        <= 3'd0;
         r_crc         <= 16'h0000;
         r_level       <= 1'b1;
         r_type        <= 2'b00;
         r_left        <= 7'd0;
         dPlus_out     <= 1'b1;
         dMinus_out    <= 1'b0;
         tx_done       <= 1'b0;
         get_tx_packet <= 1'b0;
      end else begin
         r_state       <= w_state;
         r_tick        <= w_tick;
         r_phase       <= w_phase;
         r_shift       <= w_shift;
         r_bitcnt      <= w_bitcnt;
         r_ones        <= w_ones;
         r_crc         <= w_crc;
         r_level       <= w_level;
         r_type        <= w_type;
         r_left        <= w_left;
         dPlus_out     <= w_dp;
         dMinus_out    <= w_dm;
         tx_done       <= w_done;
         get_tx_packet <= w_get;
      end
   end

endmodule

// File: tb/tb_usb_tx.sv
// tb_usb_tx: directed checks of usb_tx framing, NRZI, stuffing, CRC,
// bit timing, handshake pulses and asynchronous reset.
module tb_usb_tx;

   logic       clk = 1'b0;
   logic       n_rst = 1'b1;
   logic [1:0] tx_packet = 2'b00;
   logic [7:0] tx_packet_data = 8'h00;
   logic [6:0] tx_packet_data_size = 7'd0;
   logic       dPlus_out, dMinus_out, tx_done, get_tx_packet;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int done_cnt = 0;
   int get_cnt = 0;
   int done_cyc = 0;
   int get_cyc = 0;

   usb_tx dut (
      .clk                 (clk),
      .n_rst               (n_rst),
      .tx_packet           (tx_packet),
      .tx_packet_data      (tx_packet_data),
      .tx_packet_data_size (tx_packet_data_size),
      .dPlus_out           (dPlus_out),
      .dMinus_out          (dMinus_out),
      .tx_done             (tx_done),
      .get_tx_packet       (get_tx_packet)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (get_tx_packet === 1'b1) begin
         get_cnt++;
         get_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int bstart(input int k);
      return 25 * (k / 3) + 8 * (k % 3);
   endfunction

   // exp lists the pre-NRZI bits (stuffing included), first bit sent
   // in the most significant of the nb positions
   task automatic send(input string tag, input logic [1:0] cmd,
                       input logic [6:0] sz, input logic [7:0] d,
                       input int nb, input logic [63:0] exp,
                       input int ngets);
      logic [63:0] rx;
      logic [7:0]  lv;
      logic [5:0]  eop;
      logic        prev, a, b, c, am, bm, cm;
      int          bad, t0, g0, d0, p;
      @(negedge clk);
      tx_packet = cmd;
      tx_packet_data_size = sz;
      tx_packet_data = d;
      @(posedge clk);
      #1;
      t0 = cyc;
      tx_packet = 2'b00;
      g0 = get_cnt;
      d0 = done_cnt;
      prev = 1'b1;
      rx = '0;
      lv = '0;
      eop = '0;
      bad = 0;
      for (int i = 0; i < nb + 3; i++) begin
         p = (i % 3 == 2) ? 9 : 8;
         a = dPlus_out;
         am = dMinus_out;
         repeat (4) @(posedge clk);
         #1;
         b = dPlus_out;
         bm = dMinus_out;
         repeat (p - 5) @(posedge clk);
         #1;
         c = dPlus_out;
         cm = dMinus_out;
         @(posedge clk);
         #1;
         if (a !== b || b !== c || am !== bm || bm !== cm) bad++;
         if (i < nb) begin
            if (bm !== ~b) bad++;
            rx = {rx[62:0], (b === prev)};
            prev = b;
            if (i < 8) lv = {lv[6:0], b};
         end else begin
            eop = {eop[3:0], b, bm};
         end
      end
      chk({tag, " bits"}, rx, exp);
      chk({tag, " sync"}, {56'd0, lv}, 64'h54);
      chk({tag, " eop"}, {58'd0, eop}, 64'h02);
      chk({tag, " stable"}, bad, 0);
      chk({tag, " idle"}, {62'd0, dPlus_out, dMinus_out}, 64'h2);
      repeat (30) @(posedge clk);
      #1;
      chk({tag, " done_n"}, done_cnt - d0, 1);
      chk({tag, " done_t"}, done_cyc - t0, bstart(nb + 2));
      chk({tag, " gets"}, get_cnt - g0, ngets);
      if (ngets > 0) chk({tag, " get_t"}, get_cyc - t0, bstart(16));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst line", {62'd0, dPlus_out, dMinus_out}, 64'h2);
      chk("rst pulses", {62'd0, tx_done, get_tx_packet}, 64'h0);
      @(negedge clk);
      n_rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("idle line", {62'd0, dPlus_out, dMinus_out}, 64'h2);
      chk("idle done", done_cnt, 0);
      chk("idle get", get_cnt, 0);

      send("ack", 2'b10, 7'd0, 8'h00, 16,
           {48'd0, 8'b00000001, 8'b01001011}, 0);
      send("nak", 2'b11, 7'd5, 8'h33, 16,
           {48'd0, 8'b00000001, 8'b01011010}, 0);
      send("data_aa", 2'b01, 7'd1, 8'hAA, 40,
           {24'd0, 8'b00000001, 8'b11000011, 8'b01010101,
            8'b00000011, 8'b00000011}, 1);
      send("data_fe", 2'b01, 7'd1, 8'hFE, 42,
           {22'd0, 8'b00000001, 8'b11000011, 9'b011111101,
            8'b10000011, 9'b111101100}, 1);
      send("data_0", 2'b01, 7'd0, 8'h55, 32,
           {32'd0, 8'b00000001, 8'b11000011, 16'd0}, 0);

      @(negedge clk);
      tx_packet = 2'b01;
      tx_packet_data_size = 7'd1;
      tx_packet_data = 8'hAA;
      @(posedge clk);
      #1;
      tx_packet = 2'b00;
      repeat (153) @(posedge clk);
      #3;
      chk("pre-rst K", {63'd0, dPlus_out}, 64'h0);
      n_rst = 1'b1;
      #1;
      chk("mid-rst line", {62'd0, dPlus_out, dMinus_out}, 64'h2);
      chk("mid-rst pulses", {62'd0, tx_done, get_tx_packet}, 64'h0);
      @(negedge clk);
      n_rst = 1'b0;
      repeat (5) @(posedge clk);
      send("ack2", 2'b10, 7'd0, 8'h00, 16,
           {48'd0, 8'b00000001, 8'b01001011}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
